// File: rtl/l2_mem_ctrl_if.sv
// Two-port request/grant bus between the I/D miss handlers (master) and the
// shared L2 backing-array controller (slave).
interface l2_mem_ctrl_if;
    logic        p0_rd_en;
    logic        p1_rd_en;
    logic        p0_wr_en;
    logic        p1_wr_en;
    logic [31:0] p0_addr;
    logic [31:0] p1_addr;
    logic [31:0] p0_wr_data;
    logic [31:0] p1_wr_data;
    logic        p0_rd_granted;
    logic        p1_rd_granted;
    logic        p0_wr_granted;
    logic        p1_wr_granted;
    logic [31:0] p0_rd_data;
    logic [31:0] p1_rd_data;

    modport master (
        output p0_rd_en, p1_rd_en, p0_wr_en, p1_wr_en,
        output p0_addr, p1_addr, p0_wr_data, p1_wr_data,
        input  p0_rd_granted, p1_rd_granted, p0_wr_granted, p1_wr_granted,
        input  p0_rd_data, p1_rd_data
    );

    modport slave (
        input  p0_rd_en, p1_rd_en, p0_wr_en, p1_wr_en,
        input  p0_addr, p1_addr, p0_wr_data, p1_wr_data,
        output p0_rd_granted, p1_rd_granted, p0_wr_granted, p1_wr_granted,
        output p0_rd_data, p1_rd_data
    );
endinterface

// File: rtl/l2_mem_ctrl.sv
// Two-port arbitrated controller for a single-ported 2^ADDR_W x 32 backing array.
// Define L2_RR_ARB_EN for round-robin tie-breaking; default is fixed priority to p1.
module l2_mem_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int MAX_BURST = 8
) (
    input logic         clk,
    input logic         rst_n,
    l2_mem_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY} state_t;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic [CNT_W-1:0]  burst_reg, burst_next;

    logic [1:0]        rd_en;
    logic [1:0]        wr_en;
    logic [1:0]        req;
    logic [1:0]        rd_gnt;
    logic [1:0]        wr_gnt;
    logic              winner;
    logic [ADDR_W-1:0] addr [2];
    logic [31:0]       wr_data [2];
    logic [31:0]       rd_data_reg [2];
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       mem [2**ADDR_W];
    logic              unused_addr_bits;

    assign rd_en   = {bus.p1_rd_en, bus.p0_rd_en};
    assign wr_en   = {bus.p1_wr_en, bus.p0_wr_en};
    assign req     = rd_en | wr_en;
    assign addr[0] = bus.p0_addr[ADDR_W-1:0];
    assign addr[1] = bus.p1_addr[ADDR_W-1:0];
    assign wr_data[0] = bus.p0_wr_data;
    assign wr_data[1] = bus.p1_wr_data;
    assign unused_addr_bits = ^{bus.p0_addr[31:ADDR_W], bus.p1_addr[31:ADDR_W]};

`ifdef L2_RR_ARB_EN
    logic last_reg;

    // On a tie the port served most recently yields.
    always_comb begin
        winner = req[1];
        if (req == 2'b11)
            winner = ~last_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_reg <= 1'b0;
        else if (state_reg == IDLE && req != 2'b00)
            last_reg <= winner;
    end
`else
    always_comb winner = req[1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            burst_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            burst_reg <= burst_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        burst_next = burst_reg;
        rd_gnt     = 2'b00;
        wr_gnt     = 2'b00;
        case (state_reg)
            IDLE: begin
                if (req != 2'b00) begin
                    owner_next = winner;
                    burst_next = '0;
                    state_next = rd_en[winner] ? RD_BUSY : WR_BUSY;
                end
            end
            RD_BUSY: begin
                if (!rd_en[owner_reg]) begin
                    state_next = IDLE;
                end else begin
                    rd_gnt[owner_reg] = rst_n;
                    if (burst_reg != CNT_W'(MAX_BURST))
                        burst_next = burst_reg + 1'b1;
                    if (burst_reg >= CNT_W'(MAX_BURST - 1))
                        state_next = IDLE;
                end
            end
            WR_BUSY: begin
                // Single beat: leave whether or not the requester is still asking.
                wr_gnt[owner_reg] = wr_en[owner_reg] & rst_n;
                state_next        = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_addr = addr[owner_reg];

    always_ff @(posedge clk) begin
        if (wr_gnt != 2'b00)
            mem[rd_addr] <= wr_data[owner_reg];
    end

    // Owner's output register samples the array every cycle; the other port holds.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
            always_ff @(posedge clk) begin
                if (!rst_n)
                    rd_data_reg[gi] <= 32'h0;
                else if (owner_reg == 1'(gi))
                    rd_data_reg[gi] <= mem[rd_addr];
            end
        end
    endgenerate

    assign bus.p0_rd_granted = rd_gnt[0];
    assign bus.p1_rd_granted = rd_gnt[1];
    assign bus.p0_wr_granted = wr_gnt[0];
    assign bus.p1_wr_granted = wr_gnt[1];
    assign bus.p0_rd_data    = rd_data_reg[0];
    assign bus.p1_rd_data    = rd_data_reg[1];
endmodule

// File: tb/tb_l2_mem_ctrl.sv
// Directed self-checking bench for l2_mem_ctrl: bursts, writes, arbitration,
// burst limit, reset behaviour and same-port read/write ordering.
`timescale 1ns/1ps
module tb_l2_mem_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] model [0:1023];

    l2_mem_ctrl_if bus();

    l2_mem_ctrl #(.ADDR_W(10), .MAX_BURST(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_req(input int p, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.p0_rd_en = rd; bus.p0_wr_en = wr; bus.p0_addr = a; bus.p0_wr_data = d;
        end else begin
            bus.p1_rd_en = rd; bus.p1_wr_en = wr; bus.p1_addr = a; bus.p1_wr_data = d;
        end
    endtask

    function automatic logic rgnt(input int p);
        return (p == 0) ? bus.p0_rd_granted : bus.p1_rd_granted;
    endfunction

    function automatic logic wgnt(input int p);
        return (p == 0) ? bus.p0_wr_granted : bus.p1_wr_granted;
    endfunction

    function automatic logic [31:0] rdata(input int p);
        return (p == 0) ? bus.p0_rd_data : bus.p1_rd_data;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        nxt(); nxt();
        rst_n = 1'b1;
        nxt();
    endtask

    // Single write; optionally check the old data seen by the writer and the IDLE gap.
    task automatic do_write(input int p, input logic [9:0] a, input logic [31:0] d,
                            input bit chk_old, input bit hold);
        int g = 0;
        logic [31:0] old = model[a];
        set_req(p, 1'b0, 1'b1, {22'h0, a}, d);
        for (int c = 0; c < 4 && g == 0; c++) begin
            smp();
            if (wgnt(p)) g = 1;
            nxt();
        end
        check("wr_gnt", g, 1);
        if (g != 0) model[a] = d;
        smp();
        if (chk_old) check("rd_old", rdata(p), old);
        if (hold) check("wr_idle_gap", {31'h0, wgnt(p)}, 0);
        nxt();
        set_req(p, 1'b0, 1'b0, {22'h0, a}, d);
        smp();
        if (hold) check("wr_dropped", {31'h0, wgnt(p)}, 0);
        nxt();
    endtask

    // Burst read advancing the address on each grant; data is due one cycle later.
    task automatic read_burst(input int p, input logic [9:0] base, input int n);
        int beats = 0;
        int c = 0;
        logic pg = 1'b0;
        logic [9:0] ia;
        set_req(p, 1'b1, 1'b0, {22'h0, base}, 32'h0);
        while (beats < n && c < 40) begin
            smp();
            c++;
            ia = 10'(int'(base) + beats - 1);
            if (pg) check("rd_data", rdata(p), model[ia]);
            pg = rgnt(p);
            if (pg) beats++;
            nxt();
            if (pg) set_req(p, beats < n, 1'b0, 32'(int'(base) + beats), 32'h0);
        end
        set_req(p, 1'b0, 1'b0, 32'(int'(base) + beats), 32'h0);
        check("rd_beats", beats, n);
        smp();
        ia = 10'(int'(base) + beats - 1);
        if (pg) check("rd_data", rdata(p), model[ia]);
        nxt();
    endtask

    initial begin
        logic exp_p1;
        logic g [12];
        int   gcount;
        int   beats;
        int   wcnt;

        // Reset values, and no grant on the first cycle after release.
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h10, 32'h0);
        nxt(); nxt(); nxt();
        smp();
        check("rst_p1_rgnt", {31'h0, bus.p1_rd_granted}, 0);
        nxt();
        rst_n = 1'b1;
        smp();
        check("post_rst_p1_rgnt", {31'h0, bus.p1_rd_granted}, 0);
        check("post_rst_p0_wgnt", {31'h0, bus.p0_wr_granted}, 0);
        check("post_rst_p0_rdata", bus.p0_rd_data, 32'h0);
        check("post_rst_p1_rdata", bus.p1_rd_data, 32'h0);
        nxt();
        set_req(1, 1'b0, 1'b0, 32'h10, 32'h0);
        smp(); nxt();

        for (int i = 0; i < 4; i++)
            do_write(1, 10'(16 + i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);

        read_burst(1, 10'h10, 4);

        do_write(1, 10'h20, 32'hDEAD_BEEF, 1'b0, 1'b1);
        read_burst(1, 10'h20, 1);

        // Writer reading the address it writes sees the pre-write value.
        do_write(0, 10'h11, 32'h5555_AAAA, 1'b1, 1'b0);
        read_burst(0, 10'h11, 1);

        // Three contended rounds.
        do_reset();
        for (int r = 0; r < 3; r++) begin
`ifdef L2_RR_ARB_EN
            exp_p1 = (r != 1);
`else
            exp_p1 = 1'b1;
`endif
            set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
            set_req(1, 1'b1, 1'b0, 32'h12, 32'h0);
            smp(); nxt();
            smp();
            check("arb_p1_gnt", {31'h0, rgnt(1)}, {31'h0, exp_p1});
            check("arb_p0_gnt", {31'h0, rgnt(0)}, {31'h0, ~exp_p1});
            nxt();
            set_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
            set_req(1, 1'b0, 1'b0, 32'h12, 32'h0);
            smp(); nxt();
        end

        // Burst limit: p0 holds rd_en for 12 cycles.
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        gcount = 0;
        for (int c = 0; c < 12; c++) begin
            smp();
            g[c] = rgnt(0);
            if (rgnt(1)) gcount += 100;
            nxt();
        end
        set_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
        for (int c = 0; c < 9; c++) if (g[c]) gcount++;
        check("burst_grants", gcount, 8);
        check("burst_idle_gap", {31'h0, g[9]}, 0);
        check("burst_regrant", {31'h0, g[10]}, 1);
        check("burst_regrant2", {31'h0, g[11]}, 1);
        smp(); nxt();

        // Write whose grant cycle coincides with reset must not land.
        set_req(1, 1'b0, 1'b1, 32'h13, 32'h1234_5678);
        smp(); nxt();
        rst_n = 1'b0;
        smp();
        check("rst_wr_gnt", {31'h0, wgnt(1)}, 0);
        nxt();
        set_req(1, 1'b0, 1'b0, 32'h13, 32'h0);
        rst_n = 1'b1;
        smp(); nxt();

        // Reset asserted during the third beat of a burst.
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        beats = 0;
        for (int c = 0; c < 10 && beats < 3; c++) begin
            smp();
            if (rgnt(0)) beats++;
            if (beats == 3) rst_n = 1'b0;
            else nxt();
        end
        check("mid_burst_beats", beats, 3);
        nxt();
        smp();
        check("mid_rst_p0_rgnt", {31'h0, rgnt(0)}, 0);
        check("mid_rst_p0_rdata", rdata(0), 32'h0);
        check("mid_rst_p1_rdata", rdata(1), 32'h0);
        nxt();
        set_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
        rst_n = 1'b1;
        smp(); nxt();
        read_burst(1, 10'h10, 4);

        // Same port reads and writes together: read burst first, then one write.
        set_req(0, 1'b1, 1'b1, 32'h20, 32'h0BAD_F00D);
        smp();
        check("rw_c0_rgnt", {31'h0, rgnt(0)}, 0);
        nxt(); smp();
        check("rw_c1_rgnt", {31'h0, rgnt(0)}, 1);
        check("rw_c1_wgnt", {31'h0, wgnt(0)}, 0);
        nxt(); smp();
        check("rw_c2_rgnt", {31'h0, rgnt(0)}, 1);
        check("rw_c2_wgnt", {31'h0, wgnt(0)}, 0);
        check("rw_c2_rdata", rdata(0), model[10'h20]);
        nxt();
        set_req(0, 1'b0, 1'b1, 32'h20, 32'h0BAD_F00D);
        wcnt = 0;
        for (int c = 0; c < 6; c++) begin
            smp();
            if (wgnt(0)) wcnt++;
            if (rgnt(0)) wcnt += 100;
            nxt();
            if (wcnt != 0) set_req(0, 1'b0, 1'b0, 32'h20, 32'h0BAD_F00D);
        end
        check("rw_wr_pulses", wcnt, 1);
        if (wcnt == 1) model[10'h20] = 32'h0BAD_F00D;
        read_burst(0, 10'h20, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/l2_mem_ctrl.md
L2_MEM_CTRL -- requirements
Module: l2_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address bits of backing array (2^ADDR_W x 32b).
REQ-002 SHALL have parameter MAX_BURST, default 8, meaning max consecutive read-grant cycles per ownership.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports p0_rd_en, p1_rd_en  input  1  read request (p0 = I-side miss handler, p1 = D-side miss handler).
REQ-006 SHALL have ports p0_wr_en, p1_wr_en  input  1  write request.
REQ-007 SHALL have ports p0_addr, p1_addr  input  32  word address; only bits [ADDR_W-1:0] used.
REQ-008 SHALL have ports p0_wr_data, p1_wr_data  input  32  write data.
REQ-009 SHALL have ports p0_rd_granted, p1_rd_granted  output  1  read beat accepted, rd_data valid.
REQ-010 SHALL have ports p0_wr_granted, p1_wr_granted  output  1  write accepted this cycle.
REQ-011 SHALL have ports p0_rd_data, p1_rd_data  output  32  registered read data.

Function
REQ-012 SHALL implement FSM states IDLE, RD_BUSY, WR_BUSY plus owner register (0/1).
REQ-013 IDLE: any rd_en or wr_en -> arbitrate; winner's read request -> RD_BUSY, else write -> WR_BUSY; owner = winner; no request -> stay IDLE.
REQ-014 Same port with rd_en and wr_en together SHALL be served read first; the write waits.
REQ-015 RD_BUSY: px_rd_granted = (owner==x) & px_rd_en, combinational from state; other port's grants 0.
REQ-016 Every cycle, rd_data of owner SHALL register mem[addr[ADDR_W-1:0]] sampled that cycle (1-cycle read latency); the beat at grant cycle N carries data for address presented at N-1.
REQ-017 Non-owner rd_data SHALL hold its last value.
REQ-018 RD_BUSY -> IDLE when owner rd_en drops, or after MAX_BURST granted beats (burst counter, 0 on entry, saturates, no wrap).
REQ-019 WR_BUSY: px_wr_granted = (owner==x) & px_wr_en; mem[addr] <= wr_data on that cycle; return to IDLE next cycle (single-beat write).
REQ-020 A read in the same cycle as a write to the same address SHALL return the old (pre-write) data.
REQ-021 Requester dropping rd_en/wr_en before grant SHALL be ignored; FSM returns to IDLE with no array change.
REQ-022 Returning to IDLE SHALL cost one cycle; back-to-back ownership requires IDLE in between.

Reset
REQ-023 rst_n low at clk edge SHALL force IDLE, owner=0, burst counter 0, all grants 0, all rd_data 32'h0, including mid-burst or mid-write.
REQ-024 Backing array contents SHALL NOT be reset; a write granted in the reset cycle SHALL NOT occur.
REQ-025 Grants SHALL be 0 on the first cycle after reset deasserts.

Configuration
REQ-026 Macro L2_RR_ARB_EN defined: round-robin arbitration; last-served port loses a tie in IDLE; last-served = 0 after reset.
REQ-027 L2_RR_ARB_EN undefined: fixed priority, p1 (D-side) always wins ties; no last-served state compiled.

Verification
REQ-028 Preload mem[0x10..0x13]=A0..A3; p1_rd_en=1, addr 0x10..0x13 advanced on each grant -> four p1_rd_granted beats returning A0..A3, each one cycle behind its address.
REQ-029 p1_wr_en=1, addr 0x20, data 0xDEADBEEF, then read 0x20 -> one wr_granted pulse, FSM IDLE next cycle, read returns 0xDEADBEEF.
REQ-030 p0 and p1 rd_en together, three rounds -> with L2_RR_ARB_EN ownership p1,p0,p1 (after reset p0 last-served = 0 so p1 first); without macro p1 wins all three.
REQ-031 p0 rd_en held 12 cycles, MAX_BURST=8 -> exactly 8 grants, IDLE, then p0 regranted (p1 idle).
REQ-032 rst_n low at 3rd beat of burst -> grants 0, rd_data 0x0 next cycle, array unchanged.
REQ-033 Same-port rd_en and wr_en together -> read burst completes first, then single wr_granted pulse.
